// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg: shared states, funct7 decode constants and FPU op encodings for the FP sequencer.
package fp_seq_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, WB} stateT;
  localparam logic [6:0] OPC_FP  = 7'b1010011;
  localparam logic [6:0] F7_FADD = 7'b0000000;
  localparam logic [6:0] F7_FSUB = 7'b0000100;
  localparam logic [6:0] F7_FMUL = 7'b0001000;
  localparam logic [6:0] F7_FDIV = 7'b0001100;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
endpackage

// File: rtl/fp_lat_counter.sv
// fp_lat_counter: loadable down-counter that saturates at zero and flags it.
module fp_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= loadVal;
    else if (dec && !zero) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/fp_seq_ctrl.sv
// fp_seq_ctrl: sequences multi-cycle FP R-type ops, stalls the pipe and pulses FP writeback.
module fp_seq_ctrl
  import fp_seq_pkg::*;
#(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [6:0] funct7_e,
  input  logic [4:0] rd_e,
  input  logic       flush_e,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       fp_src_d,
  output logic       fpu_start,
  output logic [1:0] fpu_op,
  output logic       stall_e,
  output logic       stall_d,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       busy,
  output logic       illegal_fp
);
  stateT state, stateNext;
  logic [4:0] rdQ;
  logic [1:0] opQ, opD;
  logic [CNT_W-1:0] latD;
  logic startQ, illegalQ, cntZero, supported, idleIssue, accept;
  assign supported = funct7_e inside {F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV};
  assign opD = funct7_e == F7_FSUB ? OP_SUB : funct7_e == F7_FMUL ? OP_MUL :
               funct7_e == F7_FDIV ? OP_DIV : OP_ADD;
  assign latD = opD == OP_MUL ? CNT_W'(LAT_MUL - 1) : opD == OP_DIV ? CNT_W'(LAT_DIV - 1) :
                CNT_W'(LAT_ADD - 1);
  assign idleIssue = state == IDLE && issue_valid && !flush_e;
  assign accept = idleIssue && supported;
  fp_lat_counter #(.W(CNT_W)) latCounter (
    .clk(clk), .reset(reset), .load(accept), .dec(state == EXEC), .loadVal(latD), .zero(cntZero)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rdQ <= '0;
      opQ <= OP_ADD;
      startQ <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      state <= stateNext;
      startQ <= accept;
      illegalQ <= idleIssue && !supported;
      if (accept) begin
        rdQ <= rd_e;
        opQ <= opD;
      end
    end
  // The accept cycle already holds the pipe and interlocks Decode against the incoming rd.
  always_comb begin
    stateNext = state == IDLE ? (accept ? EXEC : IDLE) :
                state == EXEC ? (flush_e ? IDLE : cntZero ? WB : EXEC) : IDLE;
    stall_e = accept || (state == EXEC && !flush_e);
    stall_d = fp_src_d && ((accept && (rs1_d == rd_e || rs2_d == rd_e)) ||
                           (state == EXEC && (rs1_d == rdQ || rs2_d == rdQ)));
    wb_valid = state == WB;
    busy = state != IDLE;
  end
  assign fpu_start = startQ;
  assign fpu_op = opQ;
  assign wb_rd = rdQ;
  assign illegal_fp = illegalQ;
endmodule

// File: tb/tb_fp_seq_ctrl.sv
// tb_fp_seq_ctrl: table-driven FP sequencer checks with a writeback scoreboard.
module tb_fp_seq_ctrl;
  logic clk = 1'b0, reset = 1'b1, issue_valid = 1'b0, flush_e = 1'b0, fp_src_d = 1'b0;
  logic [6:0] funct7_e = '0;
  logic [4:0] rd_e = '0, rs1_d = '0, rs2_d = '0;
  logic fpu_start, stall_e, stall_d, wb_valid, busy, illegal_fp;
  logic [1:0] fpu_op;
  logic [4:0] wb_rd;
  int cyc = 0, nVec = 0, nErr = 0;
  typedef struct {logic [4:0] rd; int due;} wbExpT;
  typedef struct {logic [6:0] f7; logic [4:0] rd; logic [1:0] op; int lat; bit ill;} vecT;
  wbExpT sb[$];
  vecT vt[$];

  fp_seq_ctrl dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .funct7_e(funct7_e), .rd_e(rd_e),
    .flush_e(flush_e), .rs1_d(rs1_d), .rs2_d(rs2_d), .fp_src_d(fp_src_d), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .stall_e(stall_e), .stall_d(stall_d), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy(busy), .illegal_fp(illegal_fp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (wb_valid) begin
      wbExpT e;
      if (sb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_cycle", cyc, e.due);
      end
    end

  task automatic runOp(input logic [6:0] f7, input logic [4:0] rd, input logic [1:0] op, input int n);
    logic hit;
    tick;
    issue_valid = 1'b1;
    funct7_e = f7;
    rd_e = rd;
    hit = fp_src_d && (rs1_d == rd || rs2_d == rd);
    @(negedge clk);
    sb.push_back('{rd, cyc + n + 1});
    chk("acc_stall_e", stall_e, 1);
    chk("acc_busy", busy, 0);
    chk("acc_start", fpu_start, 0);
    chk("acc_stall_d", stall_d, hit);
    for (int k = 1; k <= n; k++) begin
      tick;
      @(negedge clk);
      chk("ex_stall_e", stall_e, 1);
      chk("ex_busy", busy, 1);
      chk("ex_start", fpu_start, k == 1);
      chk("ex_op", fpu_op, op);
      chk("ex_stall_d", stall_d, hit);
    end
    tick;
    @(negedge clk);
    chk("wb_stall_e", stall_e, 0);
    chk("wb_busy", busy, 1);
    chk("wb_stall_d", stall_d, 0);
    chk("wb_valid", wb_valid, 1);
    issue_valid = 1'b0;
  endtask

  task automatic runIllegal(input logic [6:0] f7, input logic [4:0] rd);
    tick;
    issue_valid = 1'b1;
    funct7_e = f7;
    rd_e = rd;
    @(negedge clk);
    chk("ill_stall_e", stall_e, 0);
    tick;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("ill_pulse", illegal_fp, 1);
    chk("ill_busy", busy, 0);
    chk("ill_stall_e", stall_e, 0);
    tick;
    @(negedge clk);
    chk("ill_single", illegal_fp, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    vt.push_back('{7'b0000000, 5'd5, 2'b00, 2, 1'b0});
    vt.push_back('{7'b0000100, 5'd17, 2'b01, 2, 1'b0});
    vt.push_back('{7'b0001000, 5'd7, 2'b10, 3, 1'b0});
    vt.push_back('{7'b0001100, 5'd9, 2'b11, 8, 1'b0});
    vt.push_back('{7'b1111111, 5'd4, 2'b00, 0, 1'b1});
    vt.push_back('{7'b0000001, 5'd6, 2'b00, 0, 1'b1});
    tick;
    tick;
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall_e", stall_e, 0);
    chk("rst_start", fpu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_op", fpu_op, 0);
    chk("rst_illegal", illegal_fp, 0);
    tick;
    reset = 1'b0;
    foreach (vt[i])
      if (vt[i].ill) runIllegal(vt[i].f7, vt[i].rd);
      else runOp(vt[i].f7, vt[i].rd, vt[i].op, vt[i].lat);
    runOp(7'b0001100, 5'd9, 2'b11, 8);
    runOp(7'b0001000, 5'd3, 2'b10, 3);
    fp_src_d = 1'b1;
    rs2_d = 5'd7;
    runOp(7'b0001000, 5'd7, 2'b10, 3);
    rs2_d = 5'd8;
    runOp(7'b0001000, 5'd7, 2'b10, 3);
    rs1_d = 5'd11;
    runOp(7'b0000000, 5'd11, 2'b00, 2);
    fp_src_d = 1'b0;
    rs1_d = '0;
    // flush in the second EXEC cycle of fmul.s
    tick;
    issue_valid = 1'b1;
    funct7_e = 7'b0001000;
    rd_e = 5'd12;
    @(negedge clk);
    chk("fl_acc_stall", stall_e, 1);
    tick;
    @(negedge clk);
    chk("fl_start", fpu_start, 1);
    tick;
    flush_e = 1'b1;
    @(negedge clk);
    chk("fl_stall_e", stall_e, 0);
    chk("fl_busy", busy, 1);
    tick;
    flush_e = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("fl_idle", busy, 0);
    chk("fl_stall_idle", stall_e, 0);
    repeat (4) tick;
    // flush together with issue in IDLE
    issue_valid = 1'b1;
    funct7_e = 7'b0000000;
    rd_e = 5'd6;
    flush_e = 1'b1;
    @(negedge clk);
    chk("fi_stall_e", stall_e, 0);
    tick;
    funct7_e = 7'b1111111;
    @(negedge clk);
    chk("fi_busy", busy, 0);
    chk("fi_illegal", illegal_fp, 0);
    tick;
    issue_valid = 1'b0;
    flush_e = 1'b0;
    @(negedge clk);
    chk("fi_illegal2", illegal_fp, 0);
    chk("fi_busy2", busy, 0);
    // flush in WB is ignored
    tick;
    issue_valid = 1'b1;
    funct7_e = 7'b0000000;
    rd_e = 5'd20;
    @(negedge clk);
    sb.push_back('{5'd20, cyc + 3});
    tick;
    tick;
    tick;
    flush_e = 1'b1;
    @(negedge clk);
    chk("fw_wb_valid", wb_valid, 1);
    tick;
    flush_e = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("fw_idle", busy, 0);
    // reset in EXEC cycle 4 of fdiv.s
    tick;
    issue_valid = 1'b1;
    funct7_e = 7'b0001100;
    rd_e = 5'd9;
    repeat (4) tick;
    reset = 1'b1;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("rm_busy_before", busy, 1);
    tick;
    @(negedge clk);
    chk("rm_busy", busy, 0);
    chk("rm_wb_valid", wb_valid, 0);
    chk("rm_stall_e", stall_e, 0);
    tick;
    reset = 1'b0;
    repeat (12) tick;
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
